// File: rtl/osd_timestamp_pkg.sv
// Shared widths, the channel-index width helper and the capture record type
// for the osd_timestamp_capture block.
package osd_timestamp_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_PRESCALE_W = 8;
    localparam int DEF_NCH        = 4;
    localparam int DEF_DEPTH      = 4;

    // Channel index needs at least one bit even for a single channel
    function automatic int chw(input int nch);
        if (nch > 1) begin
            return $clog2(nch);
        end else begin
            return 1;
        end
    endfunction

    localparam int DEF_CHW = chw(DEF_NCH);

    typedef struct packed {
        logic [DEF_WIDTH-1:0] ts;
        logic [DEF_CHW-1:0]   channel;
    } cap_rec_t;

endpackage

// File: rtl/osd_timestamp_fifo.sv
// Per-channel capture FIFO: registered storage, wrap-bit pointers, and
// simultaneous push+pop accepted even while full.
module osd_timestamp_fifo
    import osd_timestamp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (wptr_r == rptr_r);
    assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign push_ok_s = push && (!full || pop);
    assign pop_ok_s  = pop && !empty;
    assign dout      = mem_r[rptr_r[AW-1:0]];

    // Pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; when full the slot written is the one being popped
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/osd_timestamp_capture.sv
// Prescaled timestamp counter with per-channel event capture FIFOs merged
// round-robin into one valid/ready stream. OSD_TIMESTAMP_DROP_CNT_EN adds drop counters.
module osd_timestamp_capture
    import osd_timestamp_pkg::*;
#(
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int PRESCALE_W = DEF_PRESCALE_W,
    parameter  int NCH        = DEF_NCH,
    parameter  int DEPTH      = DEF_DEPTH,
    localparam int CHW        = chw(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      timestamp,
    output logic                  wrap,
    input  logic [NCH-1:0]        event_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_timestamp,
    output logic [CHW-1:0]        out_channel,
    output logic [NCH-1:0]        overflow,
`ifdef OSD_TIMESTAMP_DROP_CNT_EN
    output logic [NCH*8-1:0]      drop_count,
`endif
    input  logic                  clear_overflow
);

    logic [PRESCALE_W-1:0] pcnt_r;
    logic                  tick_s;
    logic [CHW-1:0]        rr_r;
    logic                  load_en_s;
    logic                  found_s;
    logic [CHW-1:0]        grant_s;
    logic [NCH-1:0]        empty_s;
    logic [NCH-1:0]        full_s;
    logic [NCH-1:0]        push_s;
    logic [NCH-1:0]        pop_s;
    logic [NCH-1:0]        drop_s;
    logic [WIDTH-1:0]      dout_s [NCH];

    assign tick_s    = enable && (pcnt_r >= prescale);
    assign load_en_s = !out_valid || out_ready;

    // Prescaler, counter and wrap pulse; load overrides a pending tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r    <= '0;
            timestamp <= '0;
            wrap      <= 1'b0;
        end else if (load) begin
            pcnt_r    <= '0;
            timestamp <= load_value;
            wrap      <= 1'b0;
        end else begin
            wrap <= tick_s && (timestamp == {WIDTH{1'b1}});
            if (tick_s) begin
                pcnt_r    <= '0;
                timestamp <= timestamp + {{(WIDTH-1){1'b0}}, 1'b1};
            end else if (enable) begin
                pcnt_r    <= pcnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end else begin
                pcnt_r    <= pcnt_r;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign push_s[i] = event_in[i] && (!full_s[i] || pop_s[i]);
        assign drop_s[i] = event_in[i] && full_s[i] && !pop_s[i];

        osd_timestamp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_s[i]),
            .din   (timestamp),
            .pop   (pop_s[i]),
            .dout  (dout_s[i]),
            .empty (empty_s[i]),
            .full  (full_s[i])
        );
    end

    // Round-robin search starting one past the last granted channel
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        grant_s = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(rr_r) + k) % NCH;
            if (!found_s && !empty_s[idx]) begin
                found_s = 1'b1;
                grant_s = CHW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pop only the granted FIFO, and only when the output register reloads
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < NCH; i++) begin
            pop_s[i] = load_en_s && found_s && (grant_s == CHW'(i));
        end
    end

    // Output record register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_timestamp <= '0;
            out_channel   <= '0;
            rr_r          <= CHW'(NCH - 1);
        end else if (load_en_s) begin
            out_valid <= found_s;
            if (found_s) begin
                out_timestamp <= dout_s[grant_s];
                out_channel   <= grant_s;
                rr_r          <= grant_s;
            end else begin
                rr_r          <= rr_r;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

    // Sticky drop flags; a drop in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= '0;
        end else if (clear_overflow) begin
            overflow <= drop_s;
        end else begin
            overflow <= overflow | drop_s;
        end
    end

`ifdef OSD_TIMESTAMP_DROP_CNT_EN
    logic [7:0] drop_cnt_r [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_dcnt
        assign drop_count[8*i +: 8] = drop_cnt_r[i];

        // Saturating per-channel drop counter
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                drop_cnt_r[i] <= 8'd0;
            end else if (clear_overflow) begin
                drop_cnt_r[i] <= {7'd0, drop_s[i]};
            end else if (drop_s[i] && (drop_cnt_r[i] != 8'hFF)) begin
                drop_cnt_r[i] <= drop_cnt_r[i] + 8'd1;
            end else begin
                drop_cnt_r[i] <= drop_cnt_r[i];
            end
        end
    end
`else
    // Only the sticky overflow flags are kept in this build
`endif

endmodule

// File: tb/tb_osd_timestamp_capture.sv
// Directed self-checking bench for osd_timestamp_capture (WIDTH=4, NCH=4, DEPTH=4).
module tb_osd_timestamp_capture;

    localparam int WIDTH = 4;
    localparam int NCH   = 4;
    localparam int CHW   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [7:0]       prescale;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] timestamp;
    logic             wrap;
    logic [NCH-1:0]   event_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_timestamp;
    logic [CHW-1:0]   out_channel;
    logic [NCH-1:0]   overflow;
    logic             clear_overflow;
`ifdef OSD_TIMESTAMP_DROP_CNT_EN
    logic [NCH*8-1:0] drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    osd_timestamp_capture #(.WIDTH(WIDTH), .PRESCALE_W(8), .NCH(NCH), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .prescale       (prescale),
        .load           (load),
        .load_value     (load_value),
        .timestamp      (timestamp),
        .wrap           (wrap),
        .event_in       (event_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_timestamp  (out_timestamp),
        .out_channel    (out_channel),
        .overflow       (overflow),
`ifdef OSD_TIMESTAMP_DROP_CNT_EN
        .drop_count     (drop_count),
`endif
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int exp_ch [4];
        int nrec;
        exp_ch = '{1, 2, 3, 0};

        rst_n = 1'b0; enable = 1'b0; prescale = 8'd0; load = 1'b0; load_value = 4'd0;
        event_in = 4'b0000; out_ready = 1'b0; clear_overflow = 1'b0;
        cyc(2);
        check_eq("rst_ts", timestamp, 32'd0);
        check_eq("rst_wrap", wrap, 32'd0);
        check_eq("rst_valid", out_valid, 32'd0);
        check_eq("rst_ovf", overflow, 32'd0);
        rst_n = 1'b1;

        // Prescale 2: ticks on edges 3, 6, 9
        prescale = 8'd2; enable = 1'b1;
        cyc(9);
        check_eq("presc_ts", timestamp, 32'd3);
        enable = 1'b0;
        cyc(3);
        check_eq("presc_hold", timestamp, 32'd3);

        // Wrap around 15 -> 0
        load = 1'b1; load_value = 4'd14;
        cyc(1);
        check_eq("load_ts", timestamp, 32'd14);
        load = 1'b0; prescale = 8'd0; enable = 1'b1;
        cyc(1);
        check_eq("wrap_ts15", timestamp, 32'd15);
        check_eq("wrap_pre", wrap, 32'd0);
        cyc(1);
        check_eq("wrap_ts0", timestamp, 32'd0);
        check_eq("wrap_pulse", wrap, 32'd1);
        cyc(1);
        check_eq("wrap_ts1", timestamp, 32'd1);
        check_eq("wrap_end", wrap, 32'd0);
        load = 1'b1; load_value = 4'd15;
        cyc(1);
        check_eq("ld15_ts", timestamp, 32'd15);
        cyc(1);
        check_eq("ld_tick_ts", timestamp, 32'd15);
        check_eq("ld_tick_nowrap", wrap, 32'd0);
        load = 1'b0; enable = 1'b0;

        // Capture latency
        load = 1'b1; load_value = 4'd5;
        cyc(1);
        load = 1'b0; out_ready = 1'b1; event_in = 4'b0001;
        cyc(1);
        event_in = 4'b0000;
        check_eq("lat_t1_valid", out_valid, 32'd0);
        cyc(1);
        check_eq("lat_t2_valid", out_valid, 32'd1);
        check_eq("lat_ts", out_timestamp, 32'd5);
        check_eq("lat_ch", out_channel, 32'd0);
        cyc(1);
        check_eq("lat_drain", out_valid, 32'd0);

        // Round-robin after last grant on channel 0
        load = 1'b1; load_value = 4'd9;
        cyc(1);
        load = 1'b0; event_in = 4'b1111;
        cyc(1);
        event_in = 4'b0000;
        check_eq("rr_t1_valid", out_valid, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check_eq("rr_valid", out_valid, 32'd1);
            check_eq("rr_ch", out_channel, exp_ch[k]);
            check_eq("rr_ts", out_timestamp, 32'd9);
        end
        cyc(1);
        check_eq("rr_end", out_valid, 32'd0);

        // Overflow: reg + 4 FIFO entries held, sixth event dropped
        out_ready = 1'b0; event_in = 4'b0100;
        cyc(6);
        event_in = 4'b0000;
        check_eq("ovf_flag", overflow, 32'h4);
        check_eq("ovf_valid", out_valid, 32'd1);
        check_eq("ovf_ch", out_channel, 32'd2);
`ifdef OSD_TIMESTAMP_DROP_CNT_EN
        check_eq("dcnt_6", drop_count[23:16], 32'd1);
`endif
        event_in = 4'b0100; clear_overflow = 1'b1;
        cyc(1);
        event_in = 4'b0000; clear_overflow = 1'b0;
        check_eq("ovf_clr_drop", overflow, 32'h4);
`ifdef OSD_TIMESTAMP_DROP_CNT_EN
        check_eq("dcnt_clr_drop", drop_count[23:16], 32'd1);
`endif
        clear_overflow = 1'b1;
        cyc(1);
        clear_overflow = 1'b0;
        check_eq("ovf_clr", overflow, 32'h0);
`ifdef OSD_TIMESTAMP_DROP_CNT_EN
        check_eq("dcnt_clr", drop_count, 32'h0);
`endif
        nrec = out_valid ? 1 : 0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            if (out_valid) begin
                nrec++;
            end
        end
        check_eq("ovf_nrec", nrec, 32'd5);

        // Async reset mid-stream
        load = 1'b1; load_value = 4'd7;
        cyc(1);
        load = 1'b0; out_ready = 1'b0; event_in = 4'b0011;
        cyc(1);
        event_in = 4'b0000;
        cyc(1);
        check_eq("pre_rst_valid", out_valid, 32'd1);
        check_eq("pre_rst_ch", out_channel, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 32'd0);
        check_eq("arst_ts", timestamp, 32'd0);
        check_eq("arst_ots", out_timestamp, 32'd0);
        check_eq("arst_ch", out_channel, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check_eq("post_rst_valid", out_valid, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
